// File: rtl/regfile_wb_sched.sv
`timescale 1ns/1ps
// Write-port scheduler for the 32x32 register file: the pipeline writeback has priority,
// long-latency results are buffered in a 2-deep FIFO, and pending destinations are tracked for decode.
module regfile_wb_sched #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        wb_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_waddr,
  output logic        issue_ready,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIM) + 1;
  localparam logic [OW-1:0] OUT_LIM    = OW'(MAX_OUT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM - 1);

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  entry_t          fifo [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic [31:0]     pending;
  logic [OW-1:0]   outstanding;
  logic [SW-1:0]   starve;

  logic            run;
  logic            non_empty;
  entry_t          head;
  logic            wb_hit;
  logic            push;
  logic            pop;
  logic            set_en;
  logic            clr_en;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  assign run       = rst;
  assign non_empty = (count != 2'd0);
  assign head      = fifo[rd_ptr];
  assign wb_hit    = wb_we && (wb_waddr != 5'd0);

  assign lu_ready    = run && (count < 2'd2);
  assign issue_ready = run && !pending[issue_waddr] && (outstanding < OUT_LIM);

  assign push = lu_valid && lu_ready;
  // A stalled pipeline yields the port to the FIFO head; otherwise the FIFO only fills idle slots.
  assign pop  = run && non_empty && (wb_stall || !wb_hit);

  assign set_en   = issue_valid && issue_ready && (issue_waddr != 5'd0);
  assign clr_en   = pop && pending[head.waddr];
  assign set_mask = set_en ? (32'd1 << issue_waddr) : 32'd0;
  assign clr_mask = clr_en ? (32'd1 << head.waddr) : 32'd0;

  // The register file forwards popped data, so a reader of that address need not stall.
  assign chk_busy1 = run && pending[chk_addr1] && (chk_addr1 != 5'd0) &&
                     !(pop && (head.waddr == chk_addr1));
  assign chk_busy2 = run && pending[chk_addr2] && (chk_addr2 != 5'd0) &&
                     !(pop && (head.waddr == chk_addr2));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = head.waddr;
      rf_wdata = head.wdata;
    end else if (run && wb_hit) begin
      rf_we    = 1'b1;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {lu_waddr, lu_wdata};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      pending     <= 32'd0;
      outstanding <= '0;
      starve      <= '0;
      wb_stall    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count   <= count + {1'b0, push} - {1'b0, pop};
      pending <= (pending | set_mask) & ~clr_mask;

      case ({set_en, clr_en})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (pop || !non_empty) starve <= '0;
      else                   starve <= starve + SW'(1);

      // The stall lasts exactly one cycle: the head always pops while it is asserted.
      if (pop)                                   wb_stall <= 1'b0;
      else if (non_empty && starve == STARVE_TOP) wb_stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
`timescale 1ns/1ps
// Directed bench for regfile_wb_sched: expected register-file writes are queued as stimulus
// is driven and matched in order by a monitor whenever the DUT asserts rf_we.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  regfile_wb_sched #(.MAX_OUT(4), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_ready(issue_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
    issue_valid = 1'b0; issue_waddr = '0;
    chk_addr1 = '0; chk_addr2 = '0;
  endtask

  // Inputs change 1ns after the rising edge; the caller then waits #2 before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid = 1'b1; lu_waddr = a; lu_wdata = d;
  endtask

  // Scoreboard monitor: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rf_unexpected_we", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e.waddr, e.wdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    drive_wb(5'd5, 32'hFFFF_0000);
    issue_valid = 1'b1; issue_waddr = 5'd3;
    lu_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_wb_stall", wb_stall, 0);
    check("rst_lu_ready", lu_ready, 0);
    check("rst_issue_ready", issue_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_chk_busy1", chk_busy1, 0);

    // Pipeline writeback passes straight through.
    cyc(); rst = 1'b1;
    drive_wb(5'd5, 32'hA5A5_A5A5); expect_wr(5'd5, 32'hA5A5_A5A5);
    #2;
    check("wb_rf_we", rf_we, 1);
    check("wb_rf_waddr", rf_waddr, 5);
    check("wb_rf_wdata", rf_wdata, 32'hA5A5_A5A5);
    check("wb_lu_ready", lu_ready, 1);
    check("wb_issue_ready", issue_ready, 1);

    // Pending tracking for r7.
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd7;
    #2 check("iss7_ready", issue_ready, 1);
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd7; chk_addr1 = 5'd7;
    #2 check("iss7_again_ready", issue_ready, 0);
    check("r7_busy", chk_busy1, 1);
    cyc(); drive_lu(5'd7, 32'h1234_5678); expect_wr(5'd7, 32'h1234_5678); chk_addr1 = 5'd7;
    #2 check("lu7_ready", lu_ready, 1);
    check("r7_busy_buffered", chk_busy1, 1);
    cyc(); chk_addr1 = 5'd7;
    #2 check("lu7_rf_we", rf_we, 1);
    check("r7_busy_popcycle", chk_busy1, 0);
    cyc(); chk_addr1 = 5'd7; issue_waddr = 5'd7;
    #2 check("r7_busy_after", chk_busy1, 0);
    check("r7_issue_ready_after", issue_ready, 1);

    // Outstanding limit.
    for (int r = 1; r <= 4; r++) begin
      cyc(); issue_valid = 1'b1; issue_waddr = 5'(r);
      #2 check("iss_fill_ready", issue_ready, 1);
    end
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd9; chk_addr2 = 5'd3;
    drive_lu(5'd2, 32'h0000_0022); expect_wr(5'd2, 32'h0000_0022);
    #2 check("iss9_full", issue_ready, 0);
    check("r3_busy", chk_busy2, 1);
    check("lu2_ready", lu_ready, 1);
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd9; chk_addr1 = 5'd2;
    #2 check("lu2_rf_we", rf_we, 1);
    check("iss9_popcycle", issue_ready, 0);
    check("r2_busy_popcycle", chk_busy1, 0);
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd9;
    #2 check("iss9_after_pop", issue_ready, 1);

    // Starvation: pipeline writes every cycle, FIFO fills, then one stall cycle.
    cyc(); drive_wb(5'd10, 32'h100); expect_wr(5'd10, 32'h100); drive_lu(5'd1, 32'h11);
    #2 check("starve_lu_ready0", lu_ready, 1);
    check("starve_wb_wins", rf_waddr, 10);
    cyc(); drive_wb(5'd10, 32'h101); expect_wr(5'd10, 32'h101); drive_lu(5'd3, 32'h33);
    #2 check("starve_lu_ready1", lu_ready, 1);
    check("starve_no_stall1", wb_stall, 0);
    for (int k = 2; k <= 4; k++) begin
      cyc(); drive_wb(5'd10, 32'h100 + 32'(k)); expect_wr(5'd10, 32'h100 + 32'(k));
      #2 check("starve_full_lu_ready", lu_ready, 0);
      check("starve_no_stall", wb_stall, 0);
    end
    cyc(); drive_wb(5'd10, 32'h105); expect_wr(5'd1, 32'h11);
    #2 check("stall_set", wb_stall, 1);
    check("stall_rf_waddr", rf_waddr, 1);
    check("stall_rf_wdata", rf_wdata, 32'h11);
    cyc(); drive_wb(5'd10, 32'h105); expect_wr(5'd10, 32'h105);
    #2 check("stall_clear", wb_stall, 0);
    check("post_stall_wb", rf_waddr, 10);
    cyc(); expect_wr(5'd3, 32'h33);
    #2 check("second_entry_pop", rf_waddr, 3);

    // Writeback to r0 leaves the port to the FIFO.
    cyc(); drive_lu(5'd4, 32'h44); expect_wr(5'd4, 32'h44);
    #2 check("lu4_ready", lu_ready, 1);
    cyc(); drive_wb(5'd0, 32'hDEAD_BEEF);
    #2 check("r0_rf_we", rf_we, 1);
    check("r0_rf_waddr", rf_waddr, 4);
    check("r0_rf_wdata", rf_wdata, 32'h44);

    // Reset with two buffered results and three pending registers (r9, r11, r12).
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd11;
    #2 check("iss11_ready", issue_ready, 1);
    cyc(); issue_valid = 1'b1; issue_waddr = 5'd12;
    #2 check("iss12_ready", issue_ready, 1);
    cyc(); drive_wb(5'd13, 32'h200); expect_wr(5'd13, 32'h200); drive_lu(5'd11, 32'hB1);
    chk_addr1 = 5'd11;
    #2 check("r11_busy", chk_busy1, 1);
    cyc(); drive_wb(5'd13, 32'h201); expect_wr(5'd13, 32'h201); drive_lu(5'd12, 32'hB2);
    #2 check("lu12_ready", lu_ready, 1);
    cyc(); rst = 1'b0; drive_wb(5'd13, 32'h202);
    issue_valid = 1'b1; issue_waddr = 5'd20; chk_addr1 = 5'd11; chk_addr2 = 5'd9;
    #2 check("midrst_lu_ready", lu_ready, 0);
    check("midrst_issue_ready", issue_ready, 0);
    check("midrst_rf_we", rf_we, 0);
    check("midrst_busy1", chk_busy1, 0);
    check("midrst_busy2", chk_busy2, 0);
    cyc(); rst = 1'b1;
    #2 check("postrst_lu_ready", lu_ready, 1);
    check("postrst_wb_stall", wb_stall, 0);
    check("postrst_rf_we", rf_we, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(); chk_addr1 = 5'(i); chk_addr2 = 5'(31 - i); issue_waddr = 5'(i);
      #2 check("postrst_busy1", chk_busy1, 0);
      check("postrst_busy2", chk_busy2, 0);
      check("postrst_issue_ready", issue_ready, 1);
    end

    cyc();
    #2 check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
